ieee754_half_decoder: RTL

Sequential decoder that converts an IEEE754 half-precision value back to a 16-bit two's-complement integer. It is the inverse of the integer-to-IEEE754 conversion FSM. It sits beside that FSM in the top level, driven by the same confirm strobe (`R_I`) and feeding the same `REG_SHOW` / `ERROR` path. The significand is shifted one bit per cycle, so latency depends on the exponent.

---
 rtl/ieee754_half_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ieee754_half_decoder.sv
// ieee754_half_decoder
//
// Converts an IEEE754 half-precision operand (1 sign / 5 exponent / 10 fraction,
// bias 15) to a 16-bit two's-complement integer, truncating toward zero. The
// significand is shifted one bit per cycle, so latency is 2 + k cycles, where k
// is the shift distance (0..10).
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high; aborts any conversion
//   R_I      in   start strobe, sampled only while idle
//   dataIn   in   [15:0] half-precision operand, captured when R_I is accepted
//   dataOut  out  [15:0] signed integer result, held until the next completion
//   R_O      out  one-cycle result-valid pulse
//   ERROR    out  one-cycle pulse with R_O when the operand is not representable
//   busy     out  high whenever a conversion is in progress
module ieee754_half_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        R_I,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        R_O,
  output logic        ERROR,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t      r_state;
  logic [15:0] r_din;
  logic [15:0] r_m;
  logic [3:0]  r_k;
  logic        r_left;
  logic        r_err;
  logic [15:0] r_dout;
  logic        r_ro;
  logic        r_error;
  logic        r_busy;

  logic        w_s;
  logic [4:0]  w_e;
  logic [9:0]  w_f;
  logic [15:0] w_m_init;
  logic [3:0]  w_k_init;
  logic        w_left_init;
  logic        w_err_init;

  assign w_s = r_din[15];
  assign w_e = r_din[14:10];
  assign w_f = r_din[9:0];

  // Classify the captured operand: initial significand, shift distance and
  // direction. Integer value is {1,f} shifted left by (e - 25).
  always_comb begin
    w_m_init    = {5'd0, 1'b1, w_f};
    w_k_init    = '0;
    w_left_init = 1'b0;
    w_err_init  = 1'b0;
    if (w_e == 5'd31) begin
      w_err_init = 1'b1;
      w_m_init   = '0;
    end else if (w_e == 5'd30) begin
      // Only -32768 exactly fits; every other e=30 magnitude is >= 32768.
      if (w_s && (w_f == '0)) begin
        w_left_init = 1'b1;
        w_k_init    = 4'd5;
      end else begin
        w_err_init = 1'b1;
        w_m_init   = '0;
      end
    end else if (w_e <= 5'd14) begin
      w_m_init = '0;
    end else if (w_e <= 5'd24) begin
      w_k_init = 4'(5'd25 - w_e);
    end else if (w_e == 5'd25) begin
      w_k_init = '0;
    end else begin
      w_left_init = 1'b1;
      w_k_init    = 4'(w_e - 5'd25);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_din   <= '0;
      r_m     <= '0;
      r_k     <= '0;
      r_left  <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= '0;
      r_ro    <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ro    <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (R_I) begin
            r_din   <= dataIn;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_m     <= w_m_init;
          r_k     <= w_k_init;
          r_left  <= w_left_init;
          r_err   <= w_err_init;
          r_state <= (w_k_init != '0) ? S_SHIFT : S_FINISH;
        end
        S_SHIFT: begin
          r_m <= r_left ? (r_m << 1) : (r_m >> 1);
          r_k <= r_k - 4'd1;
          if (r_k == 4'd1) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // Magnitude is already truncated, so negation rounds toward zero.
          r_dout  <= r_err ? '0 : (w_s ? (16'd0 - r_m) : r_m);
          r_ro    <= 1'b1;
          r_error <= r_err;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dataOut = r_dout;
  assign R_O     = r_ro;
  assign ERROR   = r_error;
  assign busy    = r_busy;

endmodule
